// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide core: op codes, FSM states,
// iteration count and the operand magnitude helper.
package md_pkg;

   localparam logic [1:0] MD_OP_NONE = 2'd0;
   localparam logic [1:0] MD_OP_MUL  = 2'd1;
   localparam logic [1:0] MD_OP_DIV  = 2'd2;

   localparam int MD_ITERS = 32;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // Two's-complement magnitude, only when the operand is treated as signed.
   function automatic logic [31:0] md_abs(input logic [31:0] value, input logic is_signed);
      return (is_signed && value[31]) ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/md_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and emit the quotient bit.
module md_div_step (
   input  logic [31:0] rem,
   input  logic        dvd_bit,
   input  logic [31:0] divisor,
   output logic [31:0] rem_next,
   output logic        q_bit
);

   logic [32:0] shifted;
   logic [32:0] diff;

   // The shifted partial remainder needs 33 bits before the trial subtraction.
   assign shifted  = {rem, dvd_bit};
   assign diff     = shifted - {1'b0, divisor};
   assign q_bit    = (shifted >= {1'b0, divisor});
   assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/md_iter_core.sv
// Iterative 32x32 multiply / 32/32 divide responder with valid/ready handshakes.
// Define MD_FAST_MUL_EN for a single-cycle combinational multiply; divide stays iterative.
module md_iter_core
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_src0,
   input  logic [31:0] in_src1,
   input  logic [1:0]  in_op,
   input  logic        in_sign,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_res0,
   output logic [31:0] out_res1,
   output logic        out_valid,
   input  logic        out_ready
);

   md_state_e   state, state_next;
   logic        op_is_div;
   logic        neg_lo;
   logic        neg_hi;
   logic        div_zero;
   logic [4:0]  count;
   logic [31:0] opa;
   logic [31:0] src0_raw;
   logic [63:0] acc;
   logic [31:0] quot;
   logic [31:0] rem;

   logic        accept;
   logic        last_iter;
   logic        calc_done;
   logic [31:0] rem_next;
   logic        q_bit;
   logic [31:0] quot_next;
   logic [63:0] mul_res;
   logic [63:0] mul_fix;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   assign accept    = in_valid && (state == MD_IDLE) &&
                      ((in_op == MD_OP_MUL) || (in_op == MD_OP_DIV));
   assign last_iter = (count == 5'(MD_ITERS - 1));
   assign in_ready  = (state == MD_IDLE);
   assign out_valid = (state == MD_DONE);

   md_div_step u_div_step (
      .rem      (rem),
      .dvd_bit  (quot[31]),
      .divisor  (opa),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   assign quot_next = {quot[30:0], q_bit};

`ifdef MD_FAST_MUL_EN
   assign mul_res   = {32'd0, opa} * {32'd0, acc[31:0]};
   assign calc_done = op_is_div ? last_iter : 1'b1;
`else
   // Shift-add: high half accumulates the multiplicand, low half shifts out multiplier bits.
   logic [32:0] add_sum;
   assign add_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
   assign mul_res   = {add_sum, acc[31:1]};
   assign calc_done = last_iter;
`endif

   assign mul_fix = neg_lo ? (~mul_res + 64'd1) : mul_res;
   assign q_fix   = neg_lo ? (~quot_next + 32'd1) : quot_next;
   assign r_fix   = neg_hi ? (~rem_next + 32'd1) : rem_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= MD_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         MD_IDLE: if (accept)     state_next = MD_CALC;
         MD_CALC: if (calc_done)  state_next = MD_DONE;
         MD_DONE: if (out_ready)  state_next = MD_IDLE;
         default:                 state_next = MD_IDLE;
      endcase
   end

   // Operands are captured only at acceptance; results load on the final iteration edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_is_div <= 1'b0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         div_zero  <= 1'b0;
         count     <= 5'd0;
         opa       <= 32'd0;
         src0_raw  <= 32'd0;
         acc       <= 64'd0;
         quot      <= 32'd0;
         rem       <= 32'd0;
         out_res0  <= 32'd0;
         out_res1  <= 32'd0;
      end else if (accept) begin
         op_is_div <= (in_op == MD_OP_DIV);
         neg_lo    <= in_sign & (in_src0[31] ^ in_src1[31]);
         neg_hi    <= in_sign & in_src0[31];
         div_zero  <= (in_src1 == 32'd0);
         count     <= 5'd0;
         src0_raw  <= in_src0;
         rem       <= 32'd0;
         if (in_op == MD_OP_DIV) begin
            opa  <= md_abs(in_src1, in_sign);
            quot <= md_abs(in_src0, in_sign);
            acc  <= 64'd0;
         end else begin
            opa  <= md_abs(in_src0, in_sign);
            acc  <= {32'd0, md_abs(in_src1, in_sign)};
            quot <= 32'd0;
         end
      end else if (state == MD_CALC) begin
         count <= count + 5'd1;
         quot  <= quot_next;
         rem   <= rem_next;
`ifndef MD_FAST_MUL_EN
         acc   <= mul_res;
`endif
         if (calc_done) begin
            if (!op_is_div) begin
               out_res0 <= mul_fix[31:0];
               out_res1 <= mul_fix[63:32];
            end else if (div_zero) begin
               out_res0 <= 32'hFFFF_FFFF;
               out_res1 <= src0_raw;
            end else begin
               out_res0 <= q_fix;
               out_res1 <= r_fix;
            end
         end
      end
   end

endmodule
